// File: rtl/gpredict_pkg.sv
// Shared types and helpers for the parametrised global-history predictor.
// Holds the FSM encoding, mode constants and counter arithmetic.
package gpredict_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_GSELECT = 1'b0;
    localparam logic MODE_GSHARE  = 1'b1;

    // Weakly not-taken: largest value whose MSB is still 0.
    function automatic int weak_nt(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sat_step(
        input int   v,
        input logic up,
        input int   bits
    );
        int max_v;
        max_v = (1 << bits) - 1;
        if (up)
            return (v == max_v) ? v : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

endpackage

// File: rtl/gpredict_pht.sv
// Pattern history table: one combinational read port for prediction and
// one write port that either writes the init value or does a saturating
// read-modify-write. Ports: clk, i_rd_idx/o_rd_ctr, i_wr_en/i_wr_init/
// i_wr_idx/i_wr_up. Storage has no reset; the INIT sweep fills it.
module gpredict_pht
    import gpredict_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [CTR_BITS-1:0] o_rd_ctr,
    input  logic                i_wr_en,
    input  logic                i_wr_init,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_up
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [CTR_BITS-1:0] r_mem [DEPTH];
    logic [CTR_BITS-1:0] w_old;
    logic [CTR_BITS-1:0] w_new;

    // Reads see the value before this cycle's write.
    assign o_rd_ctr = r_mem[i_rd_idx];
    assign w_old    = r_mem[i_wr_idx];
    assign w_new    = i_wr_init
                    ? CTR_BITS'(weak_nt(CTR_BITS))
                    : CTR_BITS'(sat_step(int'(w_old), i_wr_up, CTR_BITS));

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_idx] <= w_new;
    end

endmodule

// File: rtl/gpredict_param.sv
// Global-history branch predictor with gselect/gshare indexing,
// speculative GHR with mispredict repair and accuracy counters.
// Ports: clk, reset (async low); predict: mode_sel, pred_valid,
// pred_ready, pred_pc -> pred_out_valid, prediction, pred_idx, pred_ghr;
// update: upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict;
// stats: stat_branches, stat_mispredicts.
module gpredict_param
    import gpredict_pkg::*;
#(
    parameter  int PC_BITS     = 8,
    parameter  int GHR_BITS    = 4,
    parameter  int PC_IDX_BITS = 4,
    parameter  int CTR_BITS    = 2,
    parameter  int STAT_BITS   = 32,
    localparam int IDX_BITS    = GHR_BITS + PC_IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode_sel,
    input  logic                 pred_valid,
    output logic                 pred_ready,
    input  logic [PC_BITS-1:0]   pred_pc,
    output logic                 pred_out_valid,
    output logic                 prediction,
    output logic [IDX_BITS-1:0]  pred_idx,
    output logic [GHR_BITS-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic [GHR_BITS-1:0]  upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    state_e               r_state;
    logic [IDX_BITS-1:0]  r_ptr;
    logic [GHR_BITS-1:0]  r_ghr;
    logic [STAT_BITS-1:0] r_br;
    logic [STAT_BITS-1:0] r_mp;
    logic                 r_pov;
    logic                 r_pred;
    logic [IDX_BITS-1:0]  r_pidx;
    logic [GHR_BITS-1:0]  r_pghr;

    logic [IDX_BITS-1:0]  w_idx;
    logic [CTR_BITS-1:0]  w_rd_ctr;
    logic                 w_pbit;
    logic                 w_init;
    logic                 w_upd;
    logic                 w_fix;
    logic                 w_accept;
    logic [GHR_BITS-1:0]  w_ghr_spec;
    logic [GHR_BITS-1:0]  w_ghr_fix;
    logic                 w_unused;

    always_comb begin
        w_idx = '0;
        unique case (mode_sel)
            MODE_GSELECT: w_idx = {pred_pc[PC_IDX_BITS-1:0], r_ghr};
            MODE_GSHARE:  w_idx = pred_pc[IDX_BITS-1:0]
                                ^ {{PC_IDX_BITS{1'b0}}, r_ghr};
        endcase
    end

    assign w_init     = (r_state == ST_INIT);
    assign w_upd      = upd_valid && !w_init;
    assign w_fix      = w_upd && upd_mispredict;
    // A repair owns the GHR this cycle, so predicts are held off.
    assign pred_ready = !w_init && !(upd_valid && upd_mispredict);
    assign w_accept   = pred_valid && pred_ready;
    assign w_pbit     = w_rd_ctr[CTR_BITS-1];

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign w_ghr_spec = w_pbit;
            assign w_ghr_fix  = upd_taken;
        end else begin : g_ghrn
            assign w_ghr_spec = {r_ghr[GHR_BITS-2:0], w_pbit};
            assign w_ghr_fix  = {upd_ghr[GHR_BITS-2:0], upd_taken};
        end
    endgenerate

    assign w_unused = ^{pred_pc, upd_ghr, w_rd_ctr};

    gpredict_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk       (clk),
        .i_rd_idx  (w_idx),
        .o_rd_ctr  (w_rd_ctr),
        .i_wr_en   (w_init || w_upd),
        .i_wr_init (w_init),
        .i_wr_idx  (w_init ? r_ptr : upd_idx),
        .i_wr_up   (upd_taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ghr   <= '0;
            r_br    <= '0;
            r_mp    <= '0;
            r_pov   <= 1'b0;
            r_pred  <= 1'b0;
            r_pidx  <= '0;
            r_pghr  <= '0;
        end else begin
            r_pov <= w_accept;
            if (w_accept) begin
                r_pred <= w_pbit;
                r_pidx <= w_idx;
                r_pghr <= r_ghr;
            end
            unique case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + IDX_BITS'(1);
                    if (r_ptr == '1)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (upd_valid) begin
                        r_br <= r_br + STAT_BITS'(1);
                        r_mp <= r_mp + STAT_BITS'(upd_mispredict);
                    end
                    if (w_fix)
                        r_ghr <= w_ghr_fix;
                    else if (w_accept)
                        r_ghr <= w_ghr_spec;
                end
            endcase
        end
    end

    assign pred_out_valid   = r_pov;
    assign prediction       = r_pred;
    assign pred_idx         = r_pidx;
    assign pred_ghr         = r_pghr;
    assign stat_branches    = r_br;
    assign stat_mispredicts = r_mp;

endmodule

// File: tb/tb_gpredict_param.sv
// Bench for gpredict_param: init sweep, hand vectors, random traffic
// against an arithmetic model, async reset and table read-back.
module tb_gpredict_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_sel;
    logic        pred_valid;
    logic        pred_ready;
    logic [7:0]  pred_pc;
    logic        pred_out_valid;
    logic        prediction;
    logic [7:0]  pred_idx;
    logic [3:0]  pred_ghr;
    logic        upd_valid;
    logic [7:0]  upd_idx;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    gpredict_param dut (
        .clk              (clk),
        .reset            (reset),
        .mode_sel         (mode_sel),
        .pred_valid       (pred_valid),
        .pred_ready       (pred_ready),
        .pred_pc          (pred_pc),
        .pred_out_valid   (pred_out_valid),
        .prediction       (prediction),
        .pred_idx         (pred_idx),
        .pred_ghr         (pred_ghr),
        .upd_valid        (upd_valid),
        .upd_idx          (upd_idx),
        .upd_ghr          (upd_ghr),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counters as plain integers 0..3, history 0..15.
    int m_pht [256];
    int m_ghr, m_br, m_mp;
    int m_idx, m_pghr;
    logic m_rdy, m_pov, m_pred, d_rdy;

    typedef struct {
        logic pv; logic [7:0] pc; logic md;
        logic uv; logic [7:0] ui; logic [3:0] ug; logic ut; logic um;
        logic e_rdy; logic e_pov; logic e_pred;
        logic [7:0] e_idx; logic [3:0] e_ghr; int e_br; int e_mp;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(
        input logic pv, input logic [7:0] pc, input logic md,
        input logic uv, input logic [7:0] ui, input logic [3:0] ug,
        input logic ut, input logic um,
        input logic er, input logic ep, input logic epr,
        input logic [7:0] ei, input logic [3:0] eg,
        input int eb, input int em);
        vec_t t;
        t.pv = pv; t.pc = pc; t.md = md;
        t.uv = uv; t.ui = ui; t.ug = ug; t.ut = ut; t.um = um;
        t.e_rdy = er; t.e_pov = ep; t.e_pred = epr;
        t.e_idx = ei; t.e_ghr = eg; t.e_br = eb; t.e_mp = em;
        return t;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 0; m_br = 0; m_mp = 0;
    endtask

    // Drives one cycle from posedge+1, samples pred_ready mid-cycle,
    // advances the model, and returns at posedge+1 of the next cycle.
    task automatic apply(input logic pv, input logic [7:0] pc,
                         input logic md, input logic uv,
                         input logic [7:0] ui, input logic [3:0] ug,
                         input logic ut, input logic um);
        pred_valid = pv; pred_pc = pc; mode_sel = md;
        upd_valid = uv; upd_idx = ui; upd_ghr = ug;
        upd_taken = ut; upd_mispredict = um;
        #1;
        d_rdy  = pred_ready;
        m_rdy  = !(uv && um);
        m_pov  = pv && m_rdy;
        if (md) m_idx = (int'(pc) ^ m_ghr) % 256;
        else    m_idx = (int'(pc) % 16) * 16 + m_ghr;
        m_pred = (m_pht[m_idx] >= 2);
        m_pghr = m_ghr;
        if (uv) begin
            if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
            else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
            m_br++;
            if (um) m_mp++;
        end
        if (uv && um)  m_ghr = (int'(ug) * 2 + int'(ut)) % 16;
        else if (m_pov) m_ghr = (m_ghr * 2 + int'(m_pred)) % 16;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string pfx);
        chk({pfx, "_ready"}, d_rdy, m_rdy);
        chk({pfx, "_pov"}, pred_out_valid, m_pov);
        if (m_pov) begin
            chk({pfx, "_pred"}, prediction, m_pred);
            chk({pfx, "_idx"}, pred_idx, m_idx);
            chk({pfx, "_ghr"}, pred_ghr, m_pghr);
        end
        chk({pfx, "_br"}, stat_branches, m_br);
        chk({pfx, "_mp"}, stat_mispredicts, m_mp);
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (!pred_ready && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++) begin
            apply(1'($urandom_range(1, 0)), 8'($urandom),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  8'($urandom), 4'($urandom), 1'($urandom_range(1, 0)),
                  ($urandom_range(3, 0) == 0));
            chk_model("rand");
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b0; pred_valid = 1'b1; pred_pc = 8'h35;
        mode_sel = 1'b0; upd_valid = 1'b0; upd_idx = '0;
        upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        model_reset();

        #1;
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_pov", pred_out_valid, 0);
        chk("rst_pred", prediction, 0);
        chk("rst_idx", pred_idx, 0);
        chk("rst_ghr", pred_ghr, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        chk("init_ready_lo", pred_ready, 0);
        wait_init(cnt);
        chk("init_cycles", cnt, 256);
        chk("init_no_pov", pred_out_valid, 0);

        apply(1'b1, 8'h35, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
        chk_model("first");
        chk("first_pred0", prediction, 0);

        tbl[0]  = mkv(0, 8'h00, 0, 1, 8'h20, 4'h0, 1, 0, 1, 0, 0, 8'h00, 4'h0, 1, 0);
        tbl[1]  = mkv(0, 8'h00, 0, 1, 8'h20, 4'h0, 1, 0, 1, 0, 0, 8'h00, 4'h0, 2, 0);
        tbl[2]  = mkv(0, 8'h00, 0, 1, 8'h20, 4'h0, 1, 0, 1, 0, 0, 8'h00, 4'h0, 3, 0);
        tbl[3]  = mkv(1, 8'h12, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 1, 8'h20, 4'h0, 3, 0);
        tbl[4]  = mkv(1, 8'h12, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 0, 8'h21, 4'h1, 3, 0);
        tbl[5]  = mkv(0, 8'h00, 0, 1, 8'h20, 4'h0, 0, 0, 1, 0, 0, 8'h00, 4'h0, 4, 0);
        tbl[6]  = mkv(1, 8'hF3, 1, 1, 8'h00, 4'h5, 0, 1, 0, 0, 0, 8'h00, 4'h0, 5, 1);
        tbl[7]  = mkv(1, 8'hF3, 1, 0, 8'h00, 4'h0, 0, 0, 1, 1, 0, 8'hF9, 4'hA, 5, 1);
        tbl[8]  = mkv(0, 8'h00, 0, 1, 8'h01, 4'h5, 0, 1, 0, 0, 0, 8'h00, 4'h0, 6, 2);
        tbl[9]  = mkv(1, 8'hF3, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 0, 8'h3A, 4'hA, 6, 2);
        tbl[10] = mkv(0, 8'h00, 0, 1, 8'h02, 4'h8, 0, 1, 0, 0, 0, 8'h00, 4'h0, 7, 3);
        tbl[11] = mkv(1, 8'h01, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 0, 8'h10, 4'h0, 7, 3);
        tbl[12] = mkv(1, 8'h01, 0, 1, 8'h10, 4'h0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 8, 4);
        tbl[13] = mkv(1, 8'h01, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 0, 8'h11, 4'h1, 8, 4);
        tbl[14] = mkv(1, 8'h03, 0, 1, 8'h32, 4'h0, 1, 0, 1, 1, 0, 8'h32, 4'h2, 9, 4);
        tbl[15] = mkv(0, 8'h00, 0, 1, 8'h03, 4'h1, 0, 1, 0, 0, 0, 8'h00, 4'h0, 10, 5);
        tbl[16] = mkv(1, 8'h03, 0, 0, 8'h00, 4'h0, 0, 0, 1, 1, 1, 8'h32, 4'h2, 10, 5);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].pv, tbl[i].pc, tbl[i].md, tbl[i].uv,
                  tbl[i].ui, tbl[i].ug, tbl[i].ut, tbl[i].um);
            chk($sformatf("vec%0d_ready", i), d_rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d_pov", i), pred_out_valid, tbl[i].e_pov);
            if (tbl[i].e_pov) begin
                chk($sformatf("vec%0d_pred", i), prediction, tbl[i].e_pred);
                chk($sformatf("vec%0d_idx", i), pred_idx, tbl[i].e_idx);
                chk($sformatf("vec%0d_ghr", i), pred_ghr, tbl[i].e_ghr);
            end
            chk($sformatf("vec%0d_br", i), stat_branches, tbl[i].e_br);
            chk($sformatf("vec%0d_mp", i), stat_mispredicts, tbl[i].e_mp);
        end

        rand_run(300);

        // Async reset: outputs must clear before any clock edge.
        pred_valid = 1'b0; upd_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("arst_br", stat_branches, 0);
        chk("arst_mp", stat_mispredicts, 0);
        chk("arst_ready", pred_ready, 0);
        chk("arst_pov", pred_out_valid, 0);
        chk("arst_ghr", pred_ghr, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        wait_init(cnt);
        chk("reinit_cycles", cnt, 256);

        for (int i = 0; i < 256; i++) begin
            apply(1'b1, 8'(i), 1'b1, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
            chk_model("rdbk");
        end

        rand_run(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
